keypad_code_encoder: RTL and testbench
======================================

Name: keypad_code_encoder

Overview:
- Scans a 4x4 matrix keypad, synchronizes and debounces the key contacts, and encodes each accepted press as the 4-bit command code consumed by the lock controller.
- Emits exactly one non-idle code per physical press; at all other times it drives the idle code 4'b1111.
- Sits between the keypad pins and the lock's 4-bit user-input bus.

Parameters:
- SETTLE_CYCLES, 4: clk cycles a row is driven before its columns are sampled. Must be >= 3 to cover the 2-flop sync latency.
- DEBOUNCE_CYCLES, 8: consecutive stable cycles required to accept a press, and also to accept its release. Must be >= 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- kp_col  input  4  keypad column lines, active-low, externally pulled up, asynchronous
- kp_row  output  4  keypad row drive, active-low one-hot
- code  output  4  command code; 4'b1111 = no input
- code_strobe  output  1  high for the single cycle in which code is non-idle
- key_held  output  1  high while in DEBOUNCE, EMIT or HOLD

Behaviour:
- Reset (clk edge with rst_n=0): state=SCAN, row index=0, kp_row=4'b1110, code=4'b1111, code_strobe=0, key_held=0, sync flops=4'b1111, all counters=0.
- Reset mid-operation aborts any press. A key still held after reset is detected again and emitted again.
- kp_col passes through a 2-flop synchronizer (scol). All decisions use scol only.
- Key map, row r / col c (col 0 = leftmost):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *, 0, #, D
- Codes: digits 1-9 -> 4'b0001..4'b1001; 0 -> 4'b0000; * -> 4'b1101 (cancel); # -> 4'b1110 (set passcode). A-D are unmapped.
- All outputs are registered; kp_row = ~(1 << row index).
- SCAN:
  - Settle counter counts up from 0.
  - When it reaches SETTLE_CYCLES, sample scol.
  - scol==4'b1111: row index advances (3 wraps to 0), settle counter clears.
  - Otherwise: latch scol as pattern, debounce counter=1, go to DEBOUNCE. The row stays driven.
- DEBOUNCE, each cycle:
  - scol==pattern: counter increments; reaching DEBOUNCE_CYCLES -> EMIT.
  - scol!=pattern: return to SCAN on the same row with settle counter cleared. No output.
- EMIT (one cycle):
  - If pattern has exactly one zero and the key is mapped: code=mapped value, code_strobe=1, registered so visible the cycle after entering EMIT.
  - Otherwise (multiple keys in the row, or an A-D key): nothing is emitted.
  - Always proceeds to HOLD.
- HOLD:
  - code returns to 4'b1111 and code_strobe to 0.
  - Release counter counts consecutive cycles with scol==4'b1111; any non-1111 cycle clears it.
  - Reaching DEBOUNCE_CYCLES: row index advances, go to SCAN.
  - A long press therefore yields exactly one code.
- Keys on other rows are invisible while a row is held. No rollover.
- Counter widths: $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES)+1).
- Press latency from a stable column edge is at most 4*(SETTLE_CYCLES+1) + 2 + DEBOUNCE_CYCLES + 1 cycles.
- code_strobe=1 if and only if code!=4'b1111. The two are never asserted in consecutive cycles.

Test Plan:
- Reset, then model key '5' (row1/col1 low when kp_row=4'b1101) held 1000 cycles -> exactly one cycle with code=4'b0101 and code_strobe=1; code=4'b1111 otherwise; key_held falls DEBOUNCE_CYCLES+few cycles after release.
- Bounce '7': 3-cycle low pulses separated by 2-cycle highs, then stable low -> no output during the bounce; a single 4'b0111 after the stable period of DEBOUNCE_CYCLES cycles.
- Sequential presses '*', '0', '#', '9' with full releases between -> codes 4'b1101, 4'b0000, 4'b1110, 4'b1001 in order, one strobe each.
- Key 'B' alone, then '4'+'6' pressed together (same row) -> no strobe for either; key_held asserts; scanning resumes after release.
- Release bounce on '3' (high for 3 cycles, low again, then high) -> no second code; HOLD persists until DEBOUNCE_CYCLES clean high cycles.
- Assert rst_n=0 for 1 cycle during HOLD of '1' while the key stays held -> outputs return to reset values; after the rescan, 4'b0001 is emitted once more.

Source files
------------

// File: rtl/keypad_code_encoder.sv
// 4x4 matrix keypad scanner: synchronizes and debounces the columns, then encodes
// each accepted press as a single-cycle 4-bit lock command (4'b1111 when idle).
module keypad_code_encoder #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] kp_col,
    output logic [3:0] kp_row,
    output logic [3:0] code,
    output logic       code_strobe,
    output logic       key_held
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES);
    localparam logic [3:0]    IDLE_CODE   = 4'b1111;
    localparam logic [3:0]    NO_COLUMN   = 4'b1111;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [1:0]      r_row_idx;
    logic [1:0]      w_row_next;
    logic [CW-1:0]   r_settle_cnt;
    logic [CW-1:0]   w_settle_next;
    logic [CW-1:0]   r_deb_cnt;
    logic [CW-1:0]   w_deb_next;
    logic [CW-1:0]   w_deb_inc;
    logic [CW-1:0]   r_rel_cnt;
    logic [CW-1:0]   w_rel_next;
    logic [CW-1:0]   w_rel_inc;
    logic [3:0]      r_pattern;
    logic [3:0]      w_pattern_next;
    logic [3:0]      r_kp_row;
    logic [3:0]      r_code;
    logic [3:0]      w_code_next;
    logic            r_strobe;
    logic            w_strobe_next;
    logic            r_key_held;
    logic            w_key_held_next;

    logic [1:0]      w_col;
    logic            w_single_key;
    logic            w_mapped;
    logic [3:0]      w_key_code;

    assign w_deb_inc = r_deb_cnt + CW'(1);
    assign w_rel_inc = r_rel_cnt + CW'(1);

    // Only a pattern with exactly one low column identifies a single key; A-D have no command.
    always_comb begin
        w_single_key = 1'b1;
        w_col        = 2'd0;
        case (r_pattern)
            4'b1110: w_col = 2'd0;
            4'b1101: w_col = 2'd1;
            4'b1011: w_col = 2'd2;
            4'b0111: w_col = 2'd3;
            default: w_single_key = 1'b0;
        endcase

        w_mapped   = 1'b1;
        w_key_code = IDLE_CODE;
        case ({r_row_idx, w_col})
            4'h0:    w_key_code = 4'b0001;
            4'h1:    w_key_code = 4'b0010;
            4'h2:    w_key_code = 4'b0011;
            4'h4:    w_key_code = 4'b0100;
            4'h5:    w_key_code = 4'b0101;
            4'h6:    w_key_code = 4'b0110;
            4'h8:    w_key_code = 4'b0111;
            4'h9:    w_key_code = 4'b1000;
            4'hA:    w_key_code = 4'b1001;
            4'hC:    w_key_code = 4'b1101;
            4'hD:    w_key_code = 4'b0000;
            4'hE:    w_key_code = 4'b1110;
            default: w_mapped   = 1'b0;
        endcase
    end

    // Scan/debounce/emit/hold sequencing; the driven row only changes when leaving SCAN's
    // idle sample or after a fully debounced release.
    always_comb begin
        w_state_next   = r_state;
        w_row_next     = r_row_idx;
        w_settle_next  = r_settle_cnt;
        w_deb_next     = r_deb_cnt;
        w_rel_next     = r_rel_cnt;
        w_pattern_next = r_pattern;
        w_code_next    = IDLE_CODE;
        w_strobe_next  = 1'b0;

        case (r_state)
            ST_SCAN: begin
                if (r_settle_cnt >= SETTLE_LAST) begin
                    w_settle_next = '0;
                    if (r_sync2 == NO_COLUMN) begin
                        w_row_next = r_row_idx + 2'd1;
                    end else begin
                        w_pattern_next = r_sync2;
                        w_deb_next     = CW'(1);
                        w_state_next   = ST_DEBOUNCE;
                    end
                end else begin
                    w_settle_next = r_settle_cnt + CW'(1);
                end
            end

            ST_DEBOUNCE: begin
                if (r_sync2 == r_pattern) begin
                    w_deb_next = w_deb_inc;
                    if (w_deb_inc >= DEB_LAST) begin
                        w_state_next = ST_EMIT;
                    end
                end else begin
                    w_deb_next    = '0;
                    w_settle_next = '0;
                    w_state_next  = ST_SCAN;
                end
            end

            ST_EMIT: begin
                if (w_single_key && w_mapped) begin
                    w_code_next   = w_key_code;
                    w_strobe_next = 1'b1;
                end
                w_deb_next   = '0;
                w_rel_next   = '0;
                w_state_next = ST_HOLD;
            end

            ST_HOLD: begin
                if (r_sync2 == NO_COLUMN) begin
                    if (w_rel_inc >= DEB_LAST) begin
                        w_rel_next    = '0;
                        w_settle_next = '0;
                        w_row_next    = r_row_idx + 2'd1;
                        w_state_next  = ST_SCAN;
                    end else begin
                        w_rel_next = w_rel_inc;
                    end
                end else begin
                    w_rel_next = '0;
                end
            end

            default: begin
                w_state_next = ST_SCAN;
            end
        endcase

        w_key_held_next = (w_state_next != ST_SCAN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1      <= 4'b1111;
            r_sync2      <= 4'b1111;
            r_state      <= ST_SCAN;
            r_row_idx    <= 2'd0;
            r_settle_cnt <= '0;
            r_deb_cnt    <= '0;
            r_rel_cnt    <= '0;
            r_pattern    <= 4'b1111;
            r_kp_row     <= 4'b1110;
            r_code       <= IDLE_CODE;
            r_strobe     <= 1'b0;
            r_key_held   <= 1'b0;
        end else begin
            r_sync1      <= kp_col;
            r_sync2      <= r_sync1;
            r_state      <= w_state_next;
            r_row_idx    <= w_row_next;
            r_settle_cnt <= w_settle_next;
            r_deb_cnt    <= w_deb_next;
            r_rel_cnt    <= w_rel_next;
            r_pattern    <= w_pattern_next;
            r_kp_row     <= ~(4'b0001 << w_row_next);
            r_code       <= w_code_next;
            r_strobe     <= w_strobe_next;
            r_key_held   <= w_key_held_next;
        end
    end

    assign kp_row      = r_kp_row;
    assign code        = r_code;
    assign code_strobe = r_strobe;
    assign key_held    = r_key_held;

endmodule

// File: tb/tb_keypad_code_encoder.sv
// Directed bench for keypad_code_encoder: a behavioural 4x4 key matrix drives the columns
// from the scanned row, and each scenario task checks codes, strobes and hold timing.
module tb_keypad_code_encoder;

    localparam int SETTLE     = 4;
    localparam int DEB        = 8;
    localparam int MAX_LAT    = 4 * (SETTLE + 1) + 2 + DEB + 1;
    localparam int KEY_BUDGET = MAX_LAT + 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] kp_col;
    logic [3:0] kp_row;
    logic [3:0] code;
    logic       code_strobe;
    logic       key_held;

    logic [15:0] pressed = '0;

    int   testsRun = 0;
    int   testsFailed = 0;
    int   strobeCount = 0;
    int   protocolErrors = 0;
    logic [3:0] lastCode = 4'hF;
    logic prevStrobe = 1'b0;
    logic monitorOn = 1'b0;

    keypad_code_encoder #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .kp_col     (kp_col),
        .kp_row     (kp_row),
        .code       (code),
        .code_strobe(code_strobe),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its column low only while its row is being driven.
    always_comb begin
        kp_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (kp_row[r] === 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) kp_col[c] = 1'b0;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (monitorOn) begin
            if (code_strobe === 1'b1) begin
                strobeCount++;
                lastCode = code;
            end
            if ((code_strobe === 1'b1) !== (code !== 4'hF)) protocolErrors++;
            if (prevStrobe && code_strobe === 1'b1) protocolErrors++;
            prevStrobe = (code_strobe === 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pressKey(input int r, input int c);
        pressed[r*4+c] = 1'b1;
    endtask

    task automatic releaseAll();
        pressed = '0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitStrobe(input int base, input int budget, output int cycles, output bit found);
        cycles = 0;
        found  = 1'b0;
        while (cycles < budget && !found) begin
            @(negedge clk);
            cycles++;
            if (strobeCount > base) found = 1'b1;
        end
    endtask

    task automatic waitHeld(input logic level, input int budget, output int cycles, output bit found);
        cycles = 0;
        found  = 1'b0;
        while (cycles < budget && !found) begin
            @(negedge clk);
            cycles++;
            if (key_held === level) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        releaseAll();
        waitCycles(3);
        testsRun++;
        if (kp_row !== 4'b1110) begin
            testsFailed++;
            $display("[TB] FAIL reset_kp_row: got %b expected %b", kp_row, 4'b1110);
        end
        testsRun++;
        if (code !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL reset_code: got %b expected %b", code, 4'b1111);
        end
        testsRun++;
        if (code_strobe !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobe: got %b expected 0", code_strobe);
        end
        testsRun++;
        if (key_held !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_key_held: got %b expected 0", key_held);
        end
        rst_n = 1'b1;
        monitorOn = 1'b1;
        waitCycles(2);
    endtask

    task automatic test_long_press();
        int  base;
        int  cyc;
        bit  found;
        base = strobeCount;
        pressKey(1, 1);
        waitStrobe(base, KEY_BUDGET, cyc, found);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL five_strobe_seen: got none within %0d cycles, expected one", KEY_BUDGET);
        end
        testsRun++;
        if (lastCode !== 4'b0101) begin
            testsFailed++;
            $display("[TB] FAIL five_code: got %b expected %b", lastCode, 4'b0101);
        end
        waitCycles(1000 - cyc);
        testsRun++;
        if (strobeCount - base !== 1) begin
            testsFailed++;
            $display("[TB] FAIL five_single_strobe: got %0d strobes expected 1", strobeCount - base);
        end
        testsRun++;
        if (key_held !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL five_held_during_press: got %b expected 1", key_held);
        end
        releaseAll();
        waitHeld(1'b0, DEB + 10, cyc, found);
        testsRun++;
        if (!found || cyc < DEB + 1 || cyc > DEB + 4) begin
            testsFailed++;
            $display("[TB] FAIL five_release_time: got %0d cycles (found=%0d) expected %0d..%0d", cyc, found, DEB + 1, DEB + 4);
        end
        waitCycles(3);
    endtask

    task automatic test_bounce();
        int  base;
        int  cyc;
        bit  found;
        base = strobeCount;
        for (int i = 0; i < 5; i++) begin
            pressKey(2, 0);
            waitCycles(3);
            releaseAll();
            waitCycles(2);
        end
        testsRun++;
        if (strobeCount !== base) begin
            testsFailed++;
            $display("[TB] FAIL bounce_quiet: got %0d strobes expected 0", strobeCount - base);
        end
        pressKey(2, 0);
        waitStrobe(base, KEY_BUDGET, cyc, found);
        testsRun++;
        if (!found || lastCode !== 4'b0111) begin
            testsFailed++;
            $display("[TB] FAIL seven_code: got %b (found=%0d) expected %b", lastCode, found, 4'b0111);
        end
        testsRun++;
        if (cyc < DEB + 3 || cyc > MAX_LAT) begin
            testsFailed++;
            $display("[TB] FAIL seven_latency: got %0d cycles expected %0d..%0d", cyc, DEB + 3, MAX_LAT);
        end
        waitCycles(20);
        testsRun++;
        if (strobeCount - base !== 1) begin
            testsFailed++;
            $display("[TB] FAIL seven_single_strobe: got %0d strobes expected 1", strobeCount - base);
        end
        releaseAll();
        waitHeld(1'b0, DEB + 10, cyc, found);
        waitCycles(3);
    endtask

    task automatic test_sequence();
        int         rows[4]  = '{3, 3, 3, 2};
        int         cols[4]  = '{0, 1, 2, 2};
        logic [3:0] codes[4] = '{4'b1101, 4'b0000, 4'b1110, 4'b1001};
        int  base;
        int  cyc;
        bit  found;
        for (int i = 0; i < 4; i++) begin
            base = strobeCount;
            pressKey(rows[i], cols[i]);
            waitStrobe(base, KEY_BUDGET, cyc, found);
            testsRun++;
            if (!found || lastCode !== codes[i]) begin
                testsFailed++;
                $display("[TB] FAIL seq_code_%0d: got %b (found=%0d) expected %b", i, lastCode, found, codes[i]);
            end
            waitCycles(15);
            testsRun++;
            if (strobeCount - base !== 1) begin
                testsFailed++;
                $display("[TB] FAIL seq_single_strobe_%0d: got %0d strobes expected 1", i, strobeCount - base);
            end
            releaseAll();
            waitHeld(1'b0, DEB + 10, cyc, found);
            waitCycles(3);
        end
    endtask

    task automatic test_unmapped();
        int  base;
        int  cyc;
        bit  found;
        base = strobeCount;
        pressKey(1, 3);
        waitHeld(1'b1, KEY_BUDGET, cyc, found);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL b_key_held: got key_held=%b after %0d cycles expected 1", key_held, cyc);
        end
        waitCycles(20);
        testsRun++;
        if (strobeCount !== base || key_held !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b_no_strobe: got %0d strobes key_held=%b expected 0 strobes key_held=1", strobeCount - base, key_held);
        end
        releaseAll();
        waitHeld(1'b0, DEB + 10, cyc, found);
        waitCycles(3);

        pressKey(1, 0);
        pressKey(1, 2);
        waitHeld(1'b1, KEY_BUDGET, cyc, found);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL dual_key_held: got key_held=%b after %0d cycles expected 1", key_held, cyc);
        end
        waitCycles(20);
        testsRun++;
        if (strobeCount !== base) begin
            testsFailed++;
            $display("[TB] FAIL dual_no_strobe: got %0d strobes expected 0", strobeCount - base);
        end
        releaseAll();
        waitHeld(1'b0, DEB + 10, cyc, found);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL dual_release: got key_held=%b expected 0 within %0d cycles", key_held, DEB + 10);
        end
        waitCycles(3);

        pressKey(0, 1);
        waitStrobe(base, KEY_BUDGET, cyc, found);
        testsRun++;
        if (!found || lastCode !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL rescan_two_code: got %b (found=%0d) expected %b", lastCode, found, 4'b0010);
        end
        releaseAll();
        waitHeld(1'b0, DEB + 10, cyc, found);
        waitCycles(3);
    endtask

    task automatic test_release_bounce();
        int  base;
        int  cyc;
        bit  found;
        base = strobeCount;
        pressKey(0, 2);
        waitStrobe(base, KEY_BUDGET, cyc, found);
        testsRun++;
        if (!found || lastCode !== 4'b0011) begin
            testsFailed++;
            $display("[TB] FAIL three_code: got %b (found=%0d) expected %b", lastCode, found, 4'b0011);
        end
        waitCycles(10);
        releaseAll();
        waitCycles(3);
        pressKey(0, 2);
        waitCycles(4);
        testsRun++;
        if (key_held !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL three_hold_through_bounce: got %b expected 1", key_held);
        end
        releaseAll();
        waitCycles(DEB + 1);
        testsRun++;
        if (key_held !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL three_hold_until_clean: got %b expected 1 after %0d high cycles", key_held, DEB + 1);
        end
        waitHeld(1'b0, 4, cyc, found);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL three_release: got key_held=%b expected 0", key_held);
        end
        testsRun++;
        if (strobeCount - base !== 1) begin
            testsFailed++;
            $display("[TB] FAIL three_single_strobe: got %0d strobes expected 1", strobeCount - base);
        end
        waitCycles(3);
    endtask

    task automatic test_reset_in_hold();
        int  base;
        int  cyc;
        bit  found;
        base = strobeCount;
        pressKey(0, 0);
        waitStrobe(base, KEY_BUDGET, cyc, found);
        testsRun++;
        if (!found || lastCode !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL one_code: got %b (found=%0d) expected %b", lastCode, found, 4'b0001);
        end
        waitCycles(5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        testsRun++;
        if (kp_row !== 4'b1110 || code !== 4'b1111 || code_strobe !== 1'b0 || key_held !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hold_reset_outputs: got row=%b code=%b strobe=%b held=%b expected row=1110 code=1111 strobe=0 held=0",
                     kp_row, code, code_strobe, key_held);
        end
        base = strobeCount;
        waitStrobe(base, KEY_BUDGET, cyc, found);
        testsRun++;
        if (!found || lastCode !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL one_reemit: got %b (found=%0d) expected %b", lastCode, found, 4'b0001);
        end
        waitCycles(10);
        testsRun++;
        if (strobeCount - base !== 1) begin
            testsFailed++;
            $display("[TB] FAIL one_reemit_single: got %0d strobes expected 1", strobeCount - base);
        end
        releaseAll();
        waitHeld(1'b0, DEB + 10, cyc, found);
        waitCycles(3);
    endtask

    initial begin
        test_reset();
        test_long_press();
        test_bounce();
        test_sequence();
        test_unmapped();
        test_release_bounce();
        test_reset_in_hold();
        testsRun++;
        if (protocolErrors !== 0) begin
            testsFailed++;
            $display("[TB] FAIL strobe_protocol: got %0d violations expected 0", protocolErrors);
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
